// File: rtl/controller_rx_if.sv
// controller_rx_if: controller state bus from controller_rx to sys_io.
//   buttons     [7:0]  button bits from the last good packet
//   joystick_x  [7:0]  X axis, unsigned
//   joystick_y  [7:0]  Y axis, unsigned
//   valid_out          one-cycle pulse when the three fields above update
// Handshake: valid-only, no ready. valid_out is high for exactly one clk_in
// cycle and the fields are stable from that cycle until the next pulse; the
// sink cannot stall the receiver, it simply samples on valid_out.
interface controller_rx_if;
    logic [7:0] buttons;
    logic [7:0] joystick_x;
    logic [7:0] joystick_y;
    logic       valid_out;

    modport master (output buttons, joystick_x, joystick_y, valid_out);
    modport slave  (input  buttons, joystick_x, joystick_y, valid_out);
endinterface

// File: rtl/controller_rx.sv
// controller_rx: serial receiver for the handheld game controller link.
// Synchronizes the raw chip pins, frames 5-byte packets
// (SYNC_BYTE, BTN, JX, JY, CSUM with CSUM = BTN ^ JX ^ JY ^ 8'hFF) and
// presents the latest good controller state to sys_io.
// Ports:
//   clk_in, rst_in        system clock, async active-high reset
//   chip_data_raw         serial data pin (async), sampled on chip clock rise
//   chip_clk_raw          serial clock pin (async)
//   rx_bus (master)       buttons / joystick_x / joystick_y / valid_out
//   last_raw_byte [7:0]   last completed byte outside HUNT (incl. checksum)
//   err_count     [7:0]   checksum failures + mid-packet timeouts, saturating
//   link_up               high while good packets are arriving
//   state_dbg     [2:0]   FSM state: 0 HUNT, 1 BTN, 2 JX, 3 JY, 4 CSUM
module controller_rx #(
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         TIMEOUT_CYCLES = 100000,
    parameter int         CNT_W          = 17
) (
    input  logic            clk_in,
    input  logic            rst_in,
    input  logic            chip_data_raw,
    input  logic            chip_clk_raw,
    controller_rx_if.master rx_bus,
    output logic [7:0]      last_raw_byte,
    output logic [7:0]      err_count,
    output logic            link_up,
    output logic [2:0]      state_dbg
);

    typedef enum logic [2:0] {
        HUNT = 3'd0,
        BTN  = 3'd1,
        JX   = 3'd2,
        JY   = 3'd3,
        CSUM = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] T_MAX = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] T_PRE = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state, state_next;
    logic             data_s1, data_s2;
    logic             clk_s1, clk_s2, clk_s3;
    logic             rise;
    logic [7:0]       sr, sr_shift;
    logic [2:0]       bit_cnt;
    logic [CNT_W-1:0] tcnt;
    logic             timeout_fire;
    logic [7:0]       btn_hold, jx_hold, jy_hold;
    logic [7:0]       csum_exp;
    logic             byte_done, pkt_good, pkt_bad, pkt_abort, idle_timeout;

    assign rise      = clk_s2 & ~clk_s3;
    assign sr_shift  = {sr[6:0], data_s2};
    assign csum_exp  = btn_hold ^ jx_hold ^ jy_hold ^ 8'hFF;
    assign state_dbg = state;
    // Fires on the single cycle tcnt steps onto the threshold; tcnt then
    // saturates, so one idle period yields one timeout. A rise always wins.
    assign timeout_fire = ~rise & (tcnt == T_PRE);

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            data_s1 <= 1'b0;
            data_s2 <= 1'b0;
            clk_s1  <= 1'b0;
            clk_s2  <= 1'b0;
            clk_s3  <= 1'b0;
            tcnt    <= '0;
            state   <= HUNT;
        end else begin
            data_s1 <= chip_data_raw;
            data_s2 <= data_s1;
            clk_s1  <= chip_clk_raw;
            clk_s2  <= clk_s1;
            clk_s3  <= clk_s2;
            if (rise)
                tcnt <= '0;
            else if (tcnt != T_MAX)
                tcnt <= tcnt + 1'b1;
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        byte_done    = 1'b0;
        pkt_good     = 1'b0;
        pkt_bad      = 1'b0;
        pkt_abort    = 1'b0;
        idle_timeout = 1'b0;
        case (state)
            HUNT: begin
                // Sliding window: no bit counting until the marker appears.
                if (rise) begin
                    if (sr_shift == SYNC_BYTE)
                        state_next = BTN;
                end else if (timeout_fire) begin
                    idle_timeout = 1'b1;
                end
            end
            default: begin
                if (rise) begin
                    if (bit_cnt == 3'd7) begin
                        byte_done = 1'b1;
                        case (state)
                            BTN:     state_next = JX;
                            JX:      state_next = JY;
                            JY:      state_next = CSUM;
                            default: begin
                                state_next = HUNT;
                                if (sr_shift == csum_exp)
                                    pkt_good = 1'b1;
                                else
                                    pkt_bad = 1'b1;
                            end
                        endcase
                    end
                end else if (timeout_fire) begin
                    pkt_abort  = 1'b1;
                    state_next = HUNT;
                end
            end
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            sr                <= '0;
            bit_cnt           <= '0;
            btn_hold          <= '0;
            jx_hold           <= '0;
            jy_hold           <= '0;
            last_raw_byte     <= '0;
            err_count         <= '0;
            link_up           <= 1'b0;
            rx_bus.buttons    <= '0;
            rx_bus.joystick_x <= '0;
            rx_bus.joystick_y <= '0;
            rx_bus.valid_out  <= 1'b0;
        end else begin
            if (rise)
                sr <= sr_shift;
            else if (timeout_fire)
                sr <= '0;

            if (state == HUNT || pkt_abort)
                bit_cnt <= '0;
            else if (rise)
                bit_cnt <= bit_cnt + 3'd1;

            if (byte_done) begin
                last_raw_byte <= sr_shift;
                case (state)
                    BTN:     btn_hold <= sr_shift;
                    JX:      jx_hold  <= sr_shift;
                    JY:      jy_hold  <= sr_shift;
                    default: ;
                endcase
            end

            // Fields only ever change as a complete, checked set.
            rx_bus.valid_out <= pkt_good;
            if (pkt_good) begin
                rx_bus.buttons    <= btn_hold;
                rx_bus.joystick_x <= jx_hold;
                rx_bus.joystick_y <= jy_hold;
            end

            if (pkt_good)
                link_up <= 1'b1;
            else if (pkt_bad || pkt_abort || idle_timeout)
                link_up <= 1'b0;

            if ((pkt_bad || pkt_abort) && err_count != 8'hFF)
                err_count <= err_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_controller_rx.sv
module tb_controller_rx;
    localparam int         TO   = 48;
    localparam int         CW   = 6;
    localparam logic [7:0] SYNC = 8'hA5;

    logic       clk_in = 1'b0;
    logic       rst_in = 1'b0;
    logic       chip_data_raw = 1'b0;
    logic       chip_clk_raw = 1'b0;
    logic [7:0] last_raw_byte, err_count;
    logic       link_up;
    logic [2:0] state_dbg;

    controller_rx_if rx_bus();

    controller_rx #(.SYNC_BYTE(SYNC), .TIMEOUT_CYCLES(TO), .CNT_W(CW)) dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .chip_data_raw (chip_data_raw),
        .chip_clk_raw  (chip_clk_raw),
        .rx_bus        (rx_bus),
        .last_raw_byte (last_raw_byte),
        .err_count     (err_count),
        .link_up       (link_up),
        .state_dbg     (state_dbg)
    );

    // ---------------- clock ----------------
    always #5 clk_in = ~clk_in;

    int checks = 0;
    int errors = 0;
    int valid_seen = 0;
    int lo_min = 4, lo_max = 6;

    always @(negedge clk_in)
        if (rx_bus.valid_out === 1'b1) valid_seen++;

    // ---------------- reference model ----------------
    // Protocol view: an 8-bit window of the most recent bits (cleared by idle
    // timeouts); once the window shows the marker, the next 32 bits are cut
    // into four bytes and judged as a packet.
    logic [7:0] m_win;
    bit         m_collect;
    logic [7:0] m_cur;
    int         m_nbits;
    logic [7:0] m_fields[$];
    logic [7:0] exp_btn, exp_jx, exp_jy, exp_last, exp_err;
    logic       exp_link;
    int         exp_valid;

    function automatic void model_err();
        if (exp_err != 8'hFF) exp_err = exp_err + 8'd1;
    endfunction

    function automatic void model_reset();
        m_win = 8'h00; m_collect = 0; m_cur = 8'h00; m_nbits = 0;
        m_fields.delete();
        exp_btn = 0; exp_jx = 0; exp_jy = 0; exp_last = 0; exp_err = 0;
        exp_link = 0;
    endfunction

    function automatic void model_bit(input logic b);
        m_win = {m_win[6:0], b};
        if (!m_collect) begin
            if (m_win == SYNC) begin
                m_collect = 1; m_nbits = 0; m_fields.delete();
            end
        end else begin
            m_cur = {m_cur[6:0], b};
            m_nbits++;
            if (m_nbits == 8) begin
                m_nbits = 0;
                exp_last = m_cur;
                m_fields.push_back(m_cur);
                if (m_fields.size() == 4) begin
                    m_collect = 0;
                    if ((m_fields[0] ^ m_fields[1] ^ m_fields[2] ^ 8'hFF) == m_fields[3]) begin
                        exp_btn = m_fields[0]; exp_jx = m_fields[1]; exp_jy = m_fields[2];
                        exp_link = 1; exp_valid++;
                    end else begin
                        exp_link = 0; model_err();
                    end
                end
            end
        end
    endfunction

    function automatic void model_timeout();
        if (m_collect) model_err();
        m_collect = 0; m_nbits = 0;
        exp_link = 0;
        m_win = 8'h00;
    endfunction

    // ---------------- checkers ----------------
    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk8({tag, ".buttons"}, rx_bus.buttons, exp_btn);
        chk8({tag, ".jx"}, rx_bus.joystick_x, exp_jx);
        chk8({tag, ".jy"}, rx_bus.joystick_y, exp_jy);
        chk8({tag, ".last"}, last_raw_byte, exp_last);
        chk8({tag, ".err"}, err_count, exp_err);
        chk8({tag, ".link"}, {7'd0, link_up}, {7'd0, exp_link});
        chk_int({tag, ".valid_cnt"}, valid_seen, exp_valid);
    endtask

    // ---------------- drivers ----------------
    task automatic send_bit(input logic b);
        @(negedge clk_in);
        chip_data_raw = b;
        chip_clk_raw  = 1'b0;
        repeat ($urandom_range(lo_max, lo_min)) @(negedge clk_in);
        chip_clk_raw  = 1'b1;
        model_bit(b);
        repeat ($urandom_range(lo_max, lo_min)) @(negedge clk_in);
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic send_pkt(input logic [7:0] b, input logic [7:0] x,
                            input logic [7:0] y, input logic [7:0] c);
        send_byte(SYNC); send_byte(b); send_byte(x); send_byte(y); send_byte(c);
    endtask

    task automatic settle();
        repeat (10) @(negedge clk_in);
    endtask

    task automatic long_gap();
        repeat (TO + 20) @(negedge clk_in);
        model_timeout();
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        logic [7:0] b, x, y, c, v;
        int lat;
        model_reset();
        exp_valid = 0;

        // Reset state
        @(negedge clk_in);
        rst_in = 1'b1;
        #1;
        check_all("reset");
        chk8("reset.state", {5'd0, state_dbg}, 8'd0);
        repeat (4) @(negedge clk_in);
        rst_in = 1'b0;
        settle();

        // First packet with latency measurement on the final CSUM bit
        send_byte(SYNC); send_byte(8'h12); send_byte(8'h80); send_byte(8'h7F);
        v = 8'h12;
        for (int i = 7; i >= 1; i--) send_bit(v[i]);
        @(negedge clk_in);
        chip_data_raw = v[0];
        chip_clk_raw  = 1'b0;
        repeat (5) @(negedge clk_in);
        chip_clk_raw  = 1'b1;
        model_bit(v[0]);
        lat = 0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk_in);
            if (rx_bus.valid_out === 1'b1 && lat == 0) lat = i;
        end
        checks++;
        assert (lat >= 3 && lat <= 5) else begin
            errors++;
            $error("FAIL latency observed %0d expected 3..5", lat);
        end
        chk8("pkt1.buttons_const", rx_bus.buttons, 8'h12);
        chk8("pkt1.jx_const", rx_bus.joystick_x, 8'h80);
        chk8("pkt1.jy_const", rx_bus.joystick_y, 8'h7F);
        chk8("pkt1.last_const", last_raw_byte, 8'h12);
        check_all("pkt1");

        // Junk bits then a packet: window must realign
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        send_pkt(8'h00, 8'h00, 8'h00, 8'hFF);
        settle();
        chk8("realign.link_const", {7'd0, link_up}, 8'd1);
        check_all("realign");

        // Bad checksum keeps prior outputs
        send_pkt(8'h01, 8'h02, 8'h03, 8'h00);
        settle();
        chk8("badcsum.err_const", err_count, 8'd1);
        check_all("badcsum");

        // Good packet then a mid-packet stall
        send_pkt(8'h3C, 8'h44, 8'h99, 8'h3C ^ 8'h44 ^ 8'h99 ^ 8'hFF);
        settle();
        check_all("pre_stall");
        send_byte(SYNC); send_byte(8'h55);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        long_gap();
        chk8("stall.state", {5'd0, state_dbg}, 8'd0);
        check_all("stall");
        send_pkt(8'hC3, 8'h10, 8'hF0, 8'hC3 ^ 8'h10 ^ 8'hF0 ^ 8'hFF);
        settle();
        check_all("after_stall");

        // Back-to-back packets, no gap
        send_pkt(8'hAA, 8'h01, 8'hFE, 8'hAA ^ 8'h01 ^ 8'hFE ^ 8'hFF);
        send_pkt(8'h5A, 8'h7E, 8'h81, 8'h5A ^ 8'h7E ^ 8'h81 ^ 8'hFF);
        settle();
        check_all("b2b");

        // Randomized packets, gaps and bit timing
        for (int n = 0; n < 24; n++) begin
            b = 8'($urandom); x = 8'($urandom); y = 8'($urandom);
            c = b ^ x ^ y ^ 8'hFF;
            if ($urandom_range(3, 0) == 0) c = c ^ 8'($urandom_range(255, 1));
            send_pkt(b, x, y, c);
            settle();
            check_all("rand");
            if ($urandom_range(1, 0) == 1) long_gap();
        end

        // Saturation: many aborts with fast bit timing, then bad checksums
        lo_min = 4; lo_max = 4;
        for (int n = 0; n < 250; n++) begin
            send_byte(SYNC); send_bit(1'b0);
            long_gap();
        end
        for (int n = 0; n < 10; n++) send_pkt(8'h01, 8'h02, 8'h03, 8'h00);
        settle();
        chk8("sat.err_const", err_count, 8'hFF);
        check_all("sat");
        lo_min = 4; lo_max = 6;

        // Asynchronous reset in the middle of JX
        long_gap();
        send_byte(SYNC); send_byte(8'h21);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        @(negedge clk_in);
        #2 rst_in = 1'b1;
        model_reset();
        #1;
        check_all("midreset");
        chk8("midreset.state", {5'd0, state_dbg}, 8'd0);
        chip_clk_raw = 1'b0;
        repeat (5) @(negedge clk_in);
        rst_in = 1'b0;
        settle();
        send_pkt(8'h21, 8'h43, 8'h65, 8'h21 ^ 8'h43 ^ 8'h65 ^ 8'hFF);
        settle();
        chk8("postreset.buttons_const", rx_bus.buttons, 8'h21);
        check_all("postreset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
